pam_4_decode: RTL and testbench

- Receive-side PAM-4 slicer and byte packer for the Rx chain of the SERDES simulation path.
- Takes signed voltage samples, which are channel-sim or encoder output on levels -84/-28/+28/+84. Slices each sample to a 2-bit symbol and emits a per-symbol stream.
- Packs every 4 symbols into a byte, buffered in a small FIFO with a ready/valid output, for BER comparison against the Tx bitstream.

---
 rtl/pam_4_decode.sv | 152 +++++++++++++++
 tb/tb_pam_4_decode.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_4_decode.sv
// PAM-4 receive slicer with MSB-first byte packer and show-ahead byte FIFO.
// Optional low-margin sample counter is enabled by defining PAM4_DEC_MARGIN_EN.
module pam_4_decode #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int FIFO_DEPTH        = 4,
  parameter int MARGIN            = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                voltage_level_in_valid,
  input  logic                                flush,
  output logic [1:0]                          symbol_out,
  output logic                                symbol_out_valid,
  output logic [7:0]                          byte_out,
  output logic                                byte_out_valid,
  input  logic                                byte_out_ready,
  output logic                                overflow,
  output logic [31:0]                         symbol_count,
  output logic [15:0]                         margin_err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [SIGNAL_RESOLUTION:0] THR = (SIGNAL_RESOLUTION + 1)'(SYMBOL_SEPERATION);

  logic signed [SIGNAL_RESOLUTION:0] v_ext;
  logic [1:0]                        symbol_next;
  logic                              pack_pending;
  logic [1:0]                        slot;
  logic [5:0]                        partial;
  logic                              push_req;
  logic                              push;
  logic                              pop;
  logic                              full;
  logic [7:0]                        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [CNT_W-1:0]                  count;

  always_comb begin
    v_ext = {voltage_level_in[SIGNAL_RESOLUTION-1], voltage_level_in};
    if (v_ext < -THR)
      symbol_next = 2'b00;
    else if (v_ext < 0)
      symbol_next = 2'b01;
    else if (v_ext < THR)
      symbol_next = 2'b10;
    else
      symbol_next = 2'b11;
  end

  // pack_pending marks a registered symbol that still has to enter the packer next edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      symbol_out       <= 2'b00;
      symbol_out_valid <= 1'b0;
      pack_pending     <= 1'b0;
      symbol_count     <= 32'd0;
    end else begin
      symbol_out_valid <= voltage_level_in_valid;
      pack_pending     <= voltage_level_in_valid & ~flush;
      if (voltage_level_in_valid) begin
        symbol_out <= symbol_next;
        if (symbol_count != 32'hFFFF_FFFF)
          symbol_count <= symbol_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot    <= 2'd0;
      partial <= 6'd0;
    end else if (flush) begin
      slot    <= 2'd0;
      partial <= 6'd0;
    end else if (pack_pending) begin
      slot    <= slot + 2'd1;
      partial <= {partial[3:0], symbol_out};
    end
  end

  assign push_req       = pack_pending & (slot == 2'd3);
  assign byte_out_valid = (count != '0);
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign pop            = byte_out_valid & byte_out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push           = push_req & (~full | pop);
  assign byte_out       = byte_out_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!flush && push)
      mem[wr_ptr] <= {partial, symbol_out};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef PAM4_DEC_MARGIN_EN
  localparam int MW = SIGNAL_RESOLUTION + 2;
  localparam logic signed [MW-1:0] S_M   = MW'(SYMBOL_SEPERATION);
  localparam logic signed [MW-1:0] MAR_M = MW'(MARGIN);

  logic signed [MW-1:0] v_m;
  logic signed [MW-1:0] d_lo;
  logic signed [MW-1:0] d_hi;
  logic                 near_thr;

  always_comb begin
    v_m      = {{2{voltage_level_in[SIGNAL_RESOLUTION-1]}}, voltage_level_in};
    d_lo     = v_m + S_M;
    d_hi     = v_m - S_M;
    near_thr = ((d_lo > -MAR_M) && (d_lo < MAR_M)) ||
               ((v_m  > -MAR_M) && (v_m  < MAR_M)) ||
               ((d_hi > -MAR_M) && (d_hi < MAR_M));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      margin_err_count <= 16'd0;
    else if (voltage_level_in_valid && near_thr && margin_err_count != 16'hFFFF)
      margin_err_count <= margin_err_count + 16'd1;
  end
`else
  assign margin_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_pam_4_decode.sv
// Self-checking bench for pam_4_decode: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations and a random phase.
module tb_pam_4_decode;

  localparam int SR     = 8;
  localparam int S      = 56;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [SR-1:0] voltage_level_in = '0;
  logic                 voltage_level_in_valid = 1'b0;
  logic                 flush = 1'b0;
  logic                 byte_out_ready = 1'b0;
  logic [1:0]           symbol_out;
  logic                 symbol_out_valid;
  logic [7:0]           byte_out;
  logic                 byte_out_valid;
  logic                 overflow;
  logic [31:0]          symbol_count;
  logic [15:0]          margin_err_count;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  pam_4_decode #(
    .SIGNAL_RESOLUTION(SR),
    .SYMBOL_SEPERATION(S),
    .FIFO_DEPTH(DEPTH),
    .MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .voltage_level_in(voltage_level_in),
    .voltage_level_in_valid(voltage_level_in_valid),
    .flush(flush),
    .symbol_out(symbol_out),
    .symbol_out_valid(symbol_out_valid),
    .byte_out(byte_out),
    .byte_out_valid(byte_out_valid),
    .byte_out_ready(byte_out_ready),
    .overflow(overflow),
    .symbol_count(symbol_count),
    .margin_err_count(margin_err_count)
  );

  // Reference model state: what the outputs must be after the most recent edge
  logic [1:0] m_sym = 2'b00;
  logic       m_sym_valid = 1'b0;
  logic [7:0] m_fifo[$];
  logic [1:0] m_partial[$];
  logic [1:0] m_stage_sym = 2'b00;
  logic       m_stage_pending = 1'b0;
  logic       m_overflow = 1'b0;
  longint     m_count = 0;
  int         m_margin = 0;

  int         bnd_v[6]   = '{-57, -56, -1, 0, 55, 56};
  logic [1:0] bnd_exp[6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
  int         levels[4]  = '{-84, -28, 28, 84};

  function automatic logic [1:0] ref_slice(int v);
    if (v < -S) return 2'b00;
    if (v < 0)  return 2'b01;
    if (v < S)  return 2'b10;
    return 2'b11;
  endfunction

  function automatic int ref_abs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit ref_near(int v);
    return (ref_abs(v + S) < MARGIN) || (ref_abs(v) < MARGIN) || (ref_abs(v - S) < MARGIN);
  endfunction

  function automatic logic signed [SR-1:0] rand_level();
    return SR'(levels[$urandom_range(0, 3)]);
  endfunction

  task automatic model_clear();
    m_sym = 2'b00;
    m_sym_valid = 1'b0;
    m_fifo.delete();
    m_partial.delete();
    m_stage_sym = 2'b00;
    m_stage_pending = 1'b0;
    m_overflow = 1'b0;
    m_count = 0;
    m_margin = 0;
  endtask

  task automatic model_step();
    bit pop;
    logic [7:0] b;
    int v;
    pop = (m_fifo.size() != 0) && byte_out_ready;
    if (flush) begin
      m_fifo.delete();
      m_partial.delete();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (m_stage_pending) begin
        m_partial.push_back(m_stage_sym);
        if (m_partial.size() == 4) begin
          b = {m_partial[0], m_partial[1], m_partial[2], m_partial[3]};
          if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
          else m_overflow = 1'b1;
          m_partial.delete();
        end
      end
    end
    if (voltage_level_in_valid) begin
      v = voltage_level_in;
      m_sym = ref_slice(v);
      m_sym_valid = 1'b1;
      if (m_count < 64'h0000_0000_FFFF_FFFF) m_count++;
`ifdef PAM4_DEC_MARGIN_EN
      if (ref_near(v) && m_margin < 16'hFFFF) m_margin++;
`endif
      m_stage_sym = m_sym;
      m_stage_pending = !flush;
    end else begin
      m_sym_valid = 1'b0;
      m_stage_pending = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) model_clear();
    else model_step();
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check_output("symbol_out_valid", 32'(symbol_out_valid), 32'(m_sym_valid));
    check_output("symbol_out", 32'(symbol_out), 32'(m_sym));
    check_output("byte_out_valid", 32'(byte_out_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check_output("byte_out", 32'(byte_out), 32'(m_fifo[0]));
    check_output("overflow", 32'(overflow), 32'(m_overflow));
    check_output("symbol_count", symbol_count, 32'(m_count));
    check_output("margin_err_count", 32'(margin_err_count), 32'(m_margin));
  end

  task automatic apply_stimulus(input logic signed [SR-1:0] v, input logic vld, input logic fl, input logic rdy);
    voltage_level_in = v;
    voltage_level_in_valid = vld;
    flush = fl;
    byte_out_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    check_output("rst_symbol_out", 32'(symbol_out), 32'd0);
    check_output("rst_symbol_out_valid", 32'(symbol_out_valid), 32'd0);
    check_output("rst_byte_out_valid", 32'(byte_out_valid), 32'd0);
    check_output("rst_byte_out", 32'(byte_out), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_symbol_count", symbol_count, 32'd0);
    check_output("rst_margin_err_count", 32'(margin_err_count), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    reset_dut();

    // Pin the reference slicer/margin model with hand-computed values
    check_output("model_slice_-57", 32'(ref_slice(-57)), 32'd0);
    check_output("model_slice_55", 32'(ref_slice(55)), 32'd2);
    check_output("model_near_50", 32'(ref_near(50)), 32'd1);
    check_output("model_near_28", 32'(ref_near(28)), 32'd0);

    // Ideal levels back-to-back
    apply_stimulus(-84, 1'b1, 1'b0, 1'b0);
    check_output("lvl_sym0", 32'(symbol_out), 32'd0);
    apply_stimulus(-28, 1'b1, 1'b0, 1'b0);
    check_output("lvl_sym1", 32'(symbol_out), 32'd1);
    apply_stimulus(28, 1'b1, 1'b0, 1'b0);
    check_output("lvl_sym2", 32'(symbol_out), 32'd2);
    apply_stimulus(84, 1'b1, 1'b0, 1'b0);
    check_output("lvl_sym3", 32'(symbol_out), 32'd3);
    check_output("lvl_byte_latency", 32'(byte_out_valid), 32'd0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    check_output("lvl_byte_valid", 32'(byte_out_valid), 32'd1);
    check_output("lvl_byte", 32'(byte_out), 32'h1B);
    check_output("lvl_count", symbol_count, 32'd4);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    check_output("lvl_popped", 32'(byte_out_valid), 32'd0);

    // Threshold boundaries
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(SR'(bnd_v[i]), 1'b1, 1'b0, 1'b1);
      check_output("boundary_sym", 32'(symbol_out), 32'(bnd_exp[i]));
    end

    // Full FIFO with a pop coinciding with the 5th push
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(rand_level(), 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    check_output("simul_no_overflow", 32'(overflow), 32'd0);
    check_output("simul_valid", 32'(byte_out_valid), 32'd1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    check_output("simul_still_3rd", 32'(byte_out_valid), 32'd1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    check_output("simul_drained", 32'(byte_out_valid), 32'd0);
    check_output("simul_overflow_clear", 32'(overflow), 32'd0);

    // Overflow: 5 bytes with ready low
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(rand_level(), 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    check_output("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    check_output("ovf_drained", 32'(byte_out_valid), 32'd0);
    check_output("ovf_sticky", 32'(overflow), 32'd1);

    // Flush discards a partial byte
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(rand_level(), 1'b1, 1'b0, 1'b0);
    apply_stimulus(rand_level(), 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(84, 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    check_output("flush_byte", 32'(byte_out), 32'hFF);
    check_output("flush_valid", 32'(byte_out_valid), 32'd1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    check_output("flush_only_one", 32'(byte_out_valid), 32'd0);

    // Reset mid-byte, then margin samples
    apply_stimulus(84, 1'b1, 1'b0, 1'b0);
    apply_stimulus(84, 1'b1, 1'b0, 1'b0);
    reset_dut();
    apply_stimulus(3, 1'b1, 1'b0, 1'b0);
    apply_stimulus(50, 1'b1, 1'b0, 1'b0);
    apply_stimulus(28, 1'b1, 1'b0, 1'b0);
    apply_stimulus(-60, 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
`ifdef PAM4_DEC_MARGIN_EN
    check_output("margin_count", 32'(margin_err_count), 32'd3);
`else
    check_output("margin_count", 32'(margin_err_count), 32'd0);
`endif
    check_output("margin_sym_count", symbol_count, 32'd4);
    check_output("margin_byte", 32'(byte_out), 32'hA8);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic signed [SR-1:0] v;
      v = ($urandom_range(0, 1) == 0) ? rand_level() : SR'($urandom_range(0, 255));
      apply_stimulus(v, $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
